// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: I2C target exposing a 2**ADDR_W byte register file; write with a pointer byte, read with auto-increment.
module i2c_slave_regs #(
   parameter logic [6:0] SLV_ADDR = 7'h50,
   parameter int         ADDR_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i2c_scl_i,
   input  logic              i2c_sda_i,
   output logic              i2c_sda_o,
   output logic              i2c_sda_t,
   output logic              busy,
   output logic              reg_wr_vld,
   output logic [ADDR_W-1:0] reg_wr_adr,
   output logic [7:0]        reg_wr_dat,
   input  logic [ADDR_W-1:0] usr_adr,
   output logic [7:0]        usr_dat
);
   localparam logic [3:0] S_IDLE = 4'd0, S_ADDR = 4'd1, S_ADDR_ACK = 4'd2, S_PTR = 4'd3, S_PTR_ACK = 4'd4,
                          S_WR = 4'd5, S_WR_ACK = 4'd6, S_RD = 4'd7, S_RD_ACK = 4'd8, S_IGNORE = 4'd9;
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
   localparam int DEPTH = 2 ** ADDR_W;
   logic [2:0] scl_q, sda_q;
   logic [3:0] state_q, state_d, bcnt_q, bcnt_d;
   logic [7:0] shift_q, shift_d, wr_dat_q, wr_dat_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d, wr_adr_q, wr_adr_d;
   logic [7:0] regs_q [DEPTH];
   logic [7:0] regs_d [DEPTH];
   logic sda_t_q, sda_t_d, ack_q, ack_d, rw_q, rw_d, wr_vld_q, wr_vld_d;
   logic scl_rise, scl_fall, start, stop;
   // [0],[1] synchronise the pins, [2] is the previous synchronised value for edge detection
   assign scl_rise = scl_q[1] & ~scl_q[2];
   assign scl_fall = ~scl_q[1] & scl_q[2];
   assign start    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
   assign stop     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
   always_comb begin
      state_d  = state_q;
      bcnt_d   = bcnt_q;
      shift_d  = shift_q;
      ptr_d    = ptr_q;
      regs_d   = regs_q;
      sda_t_d  = sda_t_q;
      ack_d    = ack_q;
      rw_d     = rw_q;
      wr_vld_d = 1'b0;
      wr_adr_d = wr_adr_q;
      wr_dat_d = wr_dat_q;
      if (start) begin
         state_d = S_ADDR;
         bcnt_d  = 4'd0;
         ack_d   = 1'b0;
         sda_t_d = 1'b1;
      end else if (stop) begin
         state_d = S_IDLE;
         ack_d   = 1'b0;
         sda_t_d = 1'b1;
      end else if (scl_rise) begin
         case (state_q)
            S_ADDR, S_PTR, S_WR: begin
               shift_d = {shift_q[6:0], sda_q[1]};
               bcnt_d  = bcnt_q + 4'd1;
               if (bcnt_q == 4'd7) begin
                  ack_d = 1'b0;
                  if (state_q == S_ADDR) begin
                     state_d = (shift_d[7:1] == SLV_ADDR) ? S_ADDR_ACK : S_IGNORE;
                     rw_d    = sda_q[1];
                  end else if (state_q == S_PTR) begin
                     ptr_d   = shift_d[ADDR_W-1:0];
                     state_d = S_PTR_ACK;
                  end else state_d = S_WR_ACK;
               end
            end
            S_RD_ACK: begin
               state_d = sda_q[1] ? S_IGNORE : S_RD;
               if (!sda_q[1]) begin
                  shift_d = regs_q[ptr_q];
                  ptr_d   = ptr_q + PTR_ONE;
                  bcnt_d  = 4'd0;
               end
            end
            default: ;
         endcase
      end else if (scl_fall) begin
         case (state_q)
            S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
               if (!ack_q) begin
                  ack_d   = 1'b1;
                  sda_t_d = 1'b0;
                  if (state_q == S_WR_ACK) begin
                     regs_d[ptr_q] = shift_q;
                     wr_vld_d      = 1'b1;
                     wr_adr_d      = ptr_q;
                     wr_dat_d      = shift_q;
                     ptr_d         = ptr_q + PTR_ONE;
                  end
               end else begin
                  ack_d   = 1'b0;
                  sda_t_d = 1'b1;
                  bcnt_d  = 4'd0;
                  state_d = (state_q == S_ADDR_ACK) ? S_PTR : S_WR;
                  // the read MSB must appear on the very fall that ends the address ACK
                  if (state_q == S_ADDR_ACK && rw_q) begin
                     state_d = S_RD;
                     sda_t_d = regs_q[ptr_q][7];
                     shift_d = {regs_q[ptr_q][6:0], 1'b0};
                     ptr_d   = ptr_q + PTR_ONE;
                     bcnt_d  = 4'd1;
                  end
               end
            end
            S_RD: begin
               if (bcnt_q == 4'd8) begin
                  sda_t_d = 1'b1;
                  state_d = S_RD_ACK;
               end else begin
                  sda_t_d = shift_q[7];
                  shift_d = {shift_q[6:0], 1'b0};
                  bcnt_d  = bcnt_q + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_q    <= 3'b111;
         sda_q    <= 3'b111;
         state_q  <= S_IDLE;
         bcnt_q   <= 4'd0;
         shift_q  <= 8'd0;
         ptr_q    <= '0;
         regs_q   <= '{default: 8'd0};
         sda_t_q  <= 1'b1;
         ack_q    <= 1'b0;
         rw_q     <= 1'b0;
         wr_vld_q <= 1'b0;
         wr_adr_q <= '0;
         wr_dat_q <= 8'd0;
      end else begin
         scl_q    <= {scl_q[1:0], i2c_scl_i};
         sda_q    <= {sda_q[1:0], i2c_sda_i};
         state_q  <= state_d;
         bcnt_q   <= bcnt_d;
         shift_q  <= shift_d;
         ptr_q    <= ptr_d;
         regs_q   <= regs_d;
         sda_t_q  <= sda_t_d;
         ack_q    <= ack_d;
         rw_q     <= rw_d;
         wr_vld_q <= wr_vld_d;
         wr_adr_q <= wr_adr_d;
         wr_dat_q <= wr_dat_d;
      end
   end
   assign i2c_sda_o  = 1'b0;
   assign i2c_sda_t  = sda_t_q;
   assign busy       = (state_q >= S_ADDR_ACK) && (state_q <= S_RD_ACK);
   assign reg_wr_vld = wr_vld_q;
   assign reg_wr_adr = wr_adr_q;
   assign reg_wr_dat = wr_dat_q;
   assign usr_dat    = regs_q[usr_adr];
endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb_i2c_slave_regs: bit-banged I2C master against a byte-array model; register writes are scoreboarded.
module tb_i2c_slave_regs;
   localparam int Q = 10;
   typedef struct packed {logic [3:0] adr; logic [7:0] dat;} wr_t;
   logic clk = 1'b0, rst = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
   logic sda_bus, i2c_sda_o, i2c_sda_t, busy, reg_wr_vld;
   logic [3:0] reg_wr_adr, usr_adr = 4'd0;
   logic [7:0] reg_wr_dat, usr_dat;
   logic [7:0] mregs [16];
   logic [3:0] mptr = 4'd0;
   logic [7:0] txd [$];
   wr_t exp_q [$];
   wr_t mon_e;
   logic low_seen = 1'b0, busy_seen = 1'b0;
   int checks = 0, errors = 0;
   assign sda_bus = sda_m & (i2c_sda_t | i2c_sda_o);
   always #5 clk = ~clk;
   i2c_slave_regs #(.SLV_ADDR(7'h50), .ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .i2c_scl_i(scl_m), .i2c_sda_i(sda_bus), .i2c_sda_o(i2c_sda_o),
      .i2c_sda_t(i2c_sda_t), .busy(busy), .reg_wr_vld(reg_wr_vld), .reg_wr_adr(reg_wr_adr),
      .reg_wr_dat(reg_wr_dat), .usr_adr(usr_adr), .usr_dat(usr_dat)
   );
   always @(negedge clk) begin
      if (!i2c_sda_t) low_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
      if (rst && reg_wr_vld) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected: got adr %0h dat %0h, expected no write", reg_wr_adr, reg_wr_dat);
         end else begin
            mon_e = exp_q.pop_front();
            if ({reg_wr_adr, reg_wr_dat} !== mon_e) begin
               errors++;
               $display("FAIL wr_pulse: got adr %0h dat %0h, expected adr %0h dat %0h", reg_wr_adr, reg_wr_dat, mon_e.adr, mon_e.dat);
            end
         end
      end
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic bit_x(input logic b, output logic s);
      sda_m = b;
      tick(Q);
      scl_m = 1'b1;
      tick(Q);
      s = sda_bus;
      tick(Q);
      scl_m = 1'b0;
      tick(Q);
   endtask
   task automatic i2c_start;
      sda_m = 1'b1;
      tick(Q);
      scl_m = 1'b1;
      tick(Q);
      sda_m = 1'b0;
      tick(Q);
      scl_m = 1'b0;
      tick(Q);
   endtask
   task automatic i2c_stop;
      sda_m = 1'b0;
      tick(Q);
      scl_m = 1'b1;
      tick(Q);
      sda_m = 1'b1;
      tick(Q);
   endtask
   task automatic wr_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_x(b[i], s);
      bit_x(1'b1, ack);
   endtask
   task automatic rd_byte(input logic nack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_x(1'b1, s);
         b[i] = s;
      end
      bit_x(nack, s);
   endtask
   task automatic write_txn(input logic [6:0] a, input logic [7:0] p);
      logic ack;
      logic m;
      m = (a == 7'h50);
      i2c_start;
      wr_byte({a, 1'b0}, ack);
      chk("addr_ack", ack, !m);
      chk("busy_after_addr", busy, m);
      wr_byte(p, ack);
      chk("ptr_ack", ack, !m);
      if (m) mptr = p[3:0];
      foreach (txd[i]) begin
         if (m) begin
            exp_q.push_back({mptr, txd[i]});
            mregs[mptr] = txd[i];
            mptr++;
         end
         wr_byte(txd[i], ack);
         chk("data_ack", ack, !m);
      end
      i2c_stop;
      tick(Q);
      chk("busy_after_stop", busy, 1'b0);
   endtask
   task automatic read_txn(input logic setp, input logic [7:0] p, input int n);
      logic ack;
      logic [7:0] b;
      if (setp) begin
         i2c_start;
         wr_byte(8'hA0, ack);
         chk("rd_addr_w_ack", ack, 1'b0);
         wr_byte(p, ack);
         chk("rd_ptr_ack", ack, 1'b0);
         mptr = p[3:0];
      end
      i2c_start;
      wr_byte(8'hA1, ack);
      chk("rd_addr_r_ack", ack, 1'b0);
      for (int k = 0; k < n; k++) begin
         rd_byte(k == n - 1, b);
         chk("rd_data", b, mregs[mptr]);
         mptr++;
      end
      i2c_stop;
      tick(Q);
      chk("rd_sda_released", i2c_sda_t, 1'b1);
   endtask
   task automatic chk_regs;
      for (int i = 0; i < 16; i++) begin
         usr_adr = 4'(i);
         #1;
         chk("usr_dat", usr_dat, mregs[i]);
      end
   endtask
   initial begin
      logic s, ack;
      int n;
      logic [6:0] a;
      for (int i = 0; i < 16; i++) mregs[i] = 8'd0;
      tick(3);
      chk("rst_sda_t", i2c_sda_t, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_wr_vld", reg_wr_vld, 1'b0);
      rst = 1'b1;
      tick(3);
      chk_regs;
      txd = '{8'h11, 8'h22};
      write_txn(7'h50, 8'h03);
      chk_regs;
      read_txn(1'b1, 8'h03, 2);
      txd.delete();
      low_seen = 1'b0;
      busy_seen = 1'b0;
      write_txn(7'h51, 8'h55);
      chk("nack_sda_never_low", low_seen, 1'b0);
      chk("nack_busy_never", busy_seen, 1'b0);
      txd = '{8'hAA, 8'hBB, 8'hCC};
      write_txn(7'h50, 8'h0F);
      chk_regs;
      i2c_start;
      wr_byte(8'hA0, ack);
      chk("part_addr_ack", ack, 1'b0);
      wr_byte(8'h05, ack);
      chk("part_ptr_ack", ack, 1'b0);
      mptr = 4'd5;
      bit_x(1'b0, s);
      bit_x(1'b1, s);
      bit_x(1'b1, s);
      bit_x(1'b1, s);
      i2c_stop;
      tick(Q);
      chk("part_busy", busy, 1'b0);
      chk_regs;
      for (int r = 0; r < 8; r++) begin
         case ($urandom_range(0, 2))
            0: begin
               txd.delete();
               n = $urandom_range(1, 4);
               for (int k = 0; k < n; k++) txd.push_back(8'($urandom));
               a = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127)) : 7'h50;
               write_txn(a, 8'($urandom));
            end
            1: read_txn(1'b1, 8'($urandom), $urandom_range(1, 3));
            default: read_txn(1'b0, 8'h00, $urandom_range(1, 3));
         endcase
      end
      chk_regs;
      txd = '{8'h11};
      write_txn(7'h50, 8'h03);
      i2c_start;
      wr_byte(8'hA0, ack);
      wr_byte(8'h03, ack);
      i2c_start;
      wr_byte(8'hA1, ack);
      chk("rst6_addr_ack", ack, 1'b0);
      chk("rst6_driving_zero", i2c_sda_t, 1'b0);
      #3;
      rst = 1'b0;
      #1;
      chk("rst6_sda_released", i2c_sda_t, 1'b1);
      chk("rst6_busy", busy, 1'b0);
      chk("rst6_wr_vld", reg_wr_vld, 1'b0);
      for (int i = 0; i < 16; i++) mregs[i] = 8'd0;
      mptr = 4'd0;
      chk_regs;
      scl_m = 1'b1;
      sda_m = 1'b1;
      tick(4);
      rst = 1'b1;
      tick(4);
      read_txn(1'b0, 8'h00, 1);
      tick(10);
      chk("wr_queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
